regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file; successor to the single-write, two-read register file.
- Provides NR combinational read ports and NW synchronous write ports, with same-cycle write-to-read bypass.
- Holds a per-register pending-write scoreboard so decode can stall on operands whose producer has not yet written back.
- Sits between decode (reads, issue) and writeback (writes); replaces the fixed 2R/1W file.

Parameters:
- RW, 5, register address width; register count NREG = 2**RW.
- W, 32, data word width.
- NR, 2, number of read ports, minimum 1.
- NW, 2, number of write ports, minimum 1.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- rd_en  in  NR  per-port read enable.
- rd_addr  in  NR*RW  read addresses, port i at bits [i*RW +: RW].
- rd_data  out  NR*W  read data, port i at bits [i*W +: W].
- rd_busy  out  NR  1 = operand at port i is pending (consumer must stall).
- wr_en  in  NW  per-port write enable.
- wr_addr  in  NW*RW  write addresses.
- wr_data  in  NW*W  write data.
- iss_en  in  1  marks iss_addr as having an in-flight producer.
- iss_addr  in  RW  destination register of the issuing instruction.
- flush  in  1  clears all pending bits (pipeline squash).

Behaviour:
- Reset: while rst=1, all rd_data=0 and all rd_busy=0 combinationally. On a posedge with rst=1, all NREG registers are cleared to 0 and all pending bits are cleared. Writes and issues in that cycle are ignored. Reset asserted mid-operation discards in-flight state the same way.
- Register 0: always reads 0 and is never busy. Writes to it and issues to it are ignored.
- Write: on posedge, for each port j with wr_en[j]=1 and wr_addr[j]!=0, regs[wr_addr[j]] <= wr_data[j].
- Write collision: if several write ports target the same address in one cycle, the highest-index port wins.
- Read (combinational, zero latency): if rst=1, rd_en[i]=0 or rd_addr[i]=0, rd_data[i]=0.
  - Else if BYPASS=1 and any write port j has wr_en[j]=1 and wr_addr[j]=rd_addr[i], rd_data[i] is wr_data of the highest such j.
  - Else rd_data[i]=regs[rd_addr[i]].
- Scoreboard: NREG pending bits, bit 0 tied to 0.
  - On posedge, any enabled write to address a clears pending[a].
  - iss_en=1 sets pending[iss_addr].
  - If issue and write hit the same address in the same cycle, set wins (the new producer supersedes the retiring one).
  - flush=1 clears every pending bit, overriding issue. Register writes still occur in a flush cycle.
- rd_busy[i] = rd_en[i] & pending[rd_addr[i]] & ~(BYPASS & same-cycle write hit on rd_addr[i]). Forced 0 when rst=1 or rd_addr[i]=0.
- rd_busy is not a function of iss_en in the same cycle; issue takes effect from the next cycle.
- No internal pipelining: rd_data and rd_busy are purely combinational from current inputs and state. Writes and pending changes are visible from the cycle after the posedge.

Test Plan:
- Reset then read: assert rst 1 cycle, release, read r1..r31 on all ports -> every rd_data=0, rd_busy=0. Repeat with rst pulsed mid-write burst -> registers written before the pulse read 0.
- Basic write/read: wr port0 r5=0xDEADBEEF, port1 r6=0x12345678 same cycle; next cycle read r5/r6 -> 0xDEADBEEF / 0x12345678. Write r0=0xFFFFFFFF -> r0 reads 0.
- Collision and bypass: both write ports target r9 (0x1111, 0x2222) while port0 reads r9 -> rd_data=0x2222 same cycle; next cycle stored value 0x2222. With BYPASS=0, same-cycle read returns the old value.
- Scoreboard: iss r7; next cycle read r7 -> rd_busy=1. Write r7=0xAB that cycle -> rd_busy=0 (bypass hit) and rd_data=0xAB; following cycle busy=0.
- Issue/write race and flush: iss r8 and write r8 same cycle -> next cycle r8 busy=1. Issue r10, r11, then flush -> next cycle both not busy. Issue r0 -> r0 never busy.
- Parameter sweep: NR=4, NW=1, RW=4, W=16: random writes/reads checked against a reference model for 10k cycles, including all-ports-same-address reads.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: NR combinational read ports, NW write ports with
// same-cycle bypass, and a per-register pending-write scoreboard for decode stalls.
module regfile_mp #(
  parameter int RW     = 5,
  parameter int W      = 32,
  parameter int NR     = 2,
  parameter int NW     = 2,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR-1:0]    rd_en,
  input  logic [NR*RW-1:0] rd_addr,
  output logic [NR*W-1:0]  rd_data,
  output logic [NR-1:0]    rd_busy,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*RW-1:0] wr_addr,
  input  logic [NW*W-1:0]  wr_data,
  input  logic             iss_en,
  input  logic [RW-1:0]    iss_addr,
  input  logic             flush
);

  localparam int NREG = 1 << RW;

  logic [W-1:0]    regs_q [NREG];
  logic [W-1:0]    regs_d [NREG];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;
  logic [NR-1:0]   hit;
  logic [W-1:0]    byp [NR];

  // Later write ports overwrite earlier ones, so the highest index wins a collision.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int j = 0; j < NW; j++) begin
      if (wr_en[j] && wr_addr[j*RW +: RW] != '0) begin
        regs_d[wr_addr[j*RW +: RW]] = wr_data[j*W +: W];
        pend_d[wr_addr[j*RW +: RW]] = 1'b0;
      end
    end
    // A new producer supersedes the retiring one; a squash overrides both.
    if (iss_en) pend_d[iss_addr] = 1'b1;
    if (flush)  pend_d = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  // rd_busy=1 means the consumer must stall: the value on rd_data is not yet final.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    hit     = '0;
    for (int i = 0; i < NR; i++) byp[i] = '0;
    for (int i = 0; i < NR; i++) begin
      for (int j = 0; j < NW; j++) begin
        if (wr_en[j] && wr_addr[j*RW +: RW] == rd_addr[i*RW +: RW]) begin
          hit[i] = 1'b1;
          byp[i] = wr_data[j*W +: W];
        end
      end
      if (!rst && rd_en[i] && rd_addr[i*RW +: RW] != '0) begin
        if (BYPASS != 0 && hit[i]) rd_data[i*W +: W] = byp[i];
        else                       rd_data[i*W +: W] = regs_q[rd_addr[i*RW +: RW]];
        rd_busy[i] = pend_q[rd_addr[i*RW +: RW]] && !(BYPASS != 0 && hit[i]);
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing and a non-bypassing instance share
// stimulus; a negedge monitor pops queued expectations for every enabled read port.
module tb_regfile_mp;

  localparam int RW = 5;
  localparam int W  = 32;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    rd_en;
  logic [NR*RW-1:0] rd_addr;
  logic [NR*W-1:0]  rd_data, rd_data_nb;
  logic [NR-1:0]    rd_busy, rd_busy_nb;
  logic [NW-1:0]    wr_en;
  logic [NW*RW-1:0] wr_addr;
  logic [NW*W-1:0]  wr_data;
  logic             iss_en;
  logic [RW-1:0]    iss_addr;
  logic             flush;

  logic [W-1:0] exp_q[$];
  logic         exp_busy_q[$];
  logic [W-1:0] exp_nb_q[$];
  logic         exp_nb_busy_q[$];

  int errors = 0;
  int checks = 0;
  logic done = 1'b0;

  regfile_mp #(.RW(RW), .W(W), .NR(NR), .NW(NW), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
  );

  regfile_mp #(.RW(RW), .W(W), .NR(NR), .NW(NW), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic clear_inputs();
    rst = 1'b0; rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0;
    wr_data = '0; iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int i, input logic [RW-1:0] a);
    rd_en[i] = 1'b1;
    rd_addr[i*RW +: RW] = a;
  endtask

  task automatic set_wr(input int j, input logic [RW-1:0] a, input logic [W-1:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*RW +: RW] = a;
    wr_data[j*W +: W] = d;
  endtask

  task automatic set_iss(input logic [RW-1:0] a);
    iss_en = 1'b1;
    iss_addr = a;
  endtask

  // Expectations are pushed in read-port order, bypass instance and no-bypass instance.
  task automatic exp_rd(input logic [W-1:0] d, input logic b,
                        input logic [W-1:0] dn, input logic bn);
    exp_q.push_back(d);
    exp_busy_q.push_back(b);
    exp_nb_q.push_back(dn);
    exp_nb_busy_q.push_back(bn);
  endtask

  task automatic exp_same(input logic [W-1:0] d, input logic b);
    exp_rd(d, b, d, b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // Monitor / scoreboard
  logic [W-1:0] m_d, m_dn;
  logic         m_b, m_bn;

  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL leftover_expectations: %0d unconsumed, required 0", exp_q.size());
      end
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (rd_en[i]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read port%0d: no expectation queued", i);
          end else begin
            m_d  = exp_q.pop_front();
            m_b  = exp_busy_q.pop_front();
            m_dn = exp_nb_q.pop_front();
            m_bn = exp_nb_busy_q.pop_front();
            checks++;
            if (rd_data[i*W +: W] !== m_d || rd_busy[i] !== m_b) begin
              errors++;
              $display("FAIL read_bypass t=%0t port%0d addr=%0d: data=%h busy=%b, required data=%h busy=%b",
                       $time, i, rd_addr[i*RW +: RW], rd_data[i*W +: W], rd_busy[i], m_d, m_b);
            end
            checks++;
            if (rd_data_nb[i*W +: W] !== m_dn || rd_busy_nb[i] !== m_bn) begin
              errors++;
              $display("FAIL read_nobypass t=%0t port%0d addr=%0d: data=%h busy=%b, required data=%h busy=%b",
                       $time, i, rd_addr[i*RW +: RW], rd_data_nb[i*W +: W], rd_busy_nb[i], m_dn, m_bn);
            end
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    clear_inputs();
    @(posedge clk);
    #1;

    // Reset cycle: reads forced to zero while rst is high.
    rst = 1'b1;
    set_rd(0, 5'd5); set_rd(1, 5'd31);
    exp_same('0, 1'b0); exp_same('0, 1'b0);
    tick();

    // Every register reads zero and idle after reset.
    for (int a = 1; a < 32; a++) begin
      set_rd(0, 5'(a)); set_rd(1, 5'(32 - a));
      exp_same('0, 1'b0); exp_same('0, 1'b0);
      tick();
    end

    // Dual write, then read back; r0 write ignored.
    set_wr(0, 5'd5, 32'hDEADBEEF); set_wr(1, 5'd6, 32'h12345678);
    tick();
    set_rd(0, 5'd5); set_rd(1, 5'd6);
    set_wr(0, 5'd0, 32'hFFFFFFFF);
    exp_same(32'hDEADBEEF, 1'b0); exp_same(32'h12345678, 1'b0);
    tick();
    set_rd(0, 5'd0); set_rd(1, 5'd1);
    exp_same('0, 1'b0); exp_same('0, 1'b0);
    tick();

    // Collision: port1 wins, bypassed same cycle only when BYPASS=1.
    set_wr(0, 5'd9, 32'h1111); set_wr(1, 5'd9, 32'h2222);
    set_rd(0, 5'd9); set_rd(1, 5'd5);
    exp_rd(32'h2222, 1'b0, 32'h0, 1'b0); exp_same(32'hDEADBEEF, 1'b0);
    tick();
    set_rd(0, 5'd9); set_rd(1, 5'd9);
    set_wr(0, 5'd6, 32'hAAAA);
    exp_same(32'h2222, 1'b0); exp_same(32'h2222, 1'b0);
    tick();
    set_rd(1, 5'd6);
    exp_same(32'hAAAA, 1'b0);
    tick();

    // Scoreboard: issue is visible next cycle; bypassed write hides busy.
    set_iss(5'd7); set_rd(0, 5'd7);
    exp_same('0, 1'b0);
    tick();
    set_rd(0, 5'd7);
    exp_same('0, 1'b1);
    tick();
    set_rd(0, 5'd7); set_wr(1, 5'd7, 32'hAB);
    exp_rd(32'hAB, 1'b0, 32'h0, 1'b1);
    tick();
    set_rd(0, 5'd7); set_rd(1, 5'd7);
    exp_same(32'hAB, 1'b0); exp_same(32'hAB, 1'b0);
    tick();

    // Issue and write to the same register: set wins.
    set_iss(5'd8); set_wr(0, 5'd8, 32'h55);
    tick();
    set_rd(0, 5'd8); set_rd(1, 5'd8);
    exp_same(32'h55, 1'b1); exp_same(32'h55, 1'b1);
    tick();

    // Flush clears pending and overrides a same-cycle issue; its write still lands.
    set_iss(5'd10);
    tick();
    set_iss(5'd11);
    tick();
    set_rd(0, 5'd10); set_rd(1, 5'd11);
    exp_same('0, 1'b1); exp_same('0, 1'b1);
    tick();
    flush = 1'b1; set_iss(5'd12); set_wr(1, 5'd13, 32'h77);
    tick();
    set_rd(0, 5'd10); set_rd(1, 5'd11);
    exp_same('0, 1'b0); exp_same('0, 1'b0);
    tick();
    set_rd(0, 5'd12); set_rd(1, 5'd13);
    exp_same('0, 1'b0); exp_same(32'h77, 1'b0);
    tick();

    // Issue to r0 is ignored.
    set_iss(5'd0);
    tick();
    set_rd(0, 5'd0); set_rd(1, 5'd8);
    exp_same('0, 1'b0); exp_same(32'h55, 1'b0);
    tick();

    // Reset mid-burst: earlier writes and pending bits discarded, write in reset cycle ignored.
    set_wr(0, 5'd20, 32'h1); set_wr(1, 5'd21, 32'h2); set_iss(5'd15);
    tick();
    set_rd(0, 5'd15);
    exp_same('0, 1'b1);
    tick();
    rst = 1'b1; set_wr(0, 5'd22, 32'h3); set_iss(5'd23); set_rd(0, 5'd15); set_rd(1, 5'd20);
    exp_same('0, 1'b0); exp_same('0, 1'b0);
    tick();
    set_rd(0, 5'd20); set_rd(1, 5'd21);
    exp_same('0, 1'b0); exp_same('0, 1'b0);
    tick();
    set_rd(0, 5'd22); set_rd(1, 5'd15);
    exp_same('0, 1'b0); exp_same('0, 1'b0);
    tick();
    set_rd(0, 5'd23); set_rd(1, 5'd5);
    exp_same('0, 1'b0); exp_same('0, 1'b0);
    tick();

    // Final report
    done = 1'b1;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
